// File: rtl/stappdi_pkg.sv
// Shared types and helpers for the stappdi engine-side scheduler.
package stappdi_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stappdi_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module stappdi_rr_arb
  import stappdi_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PW = clog2(NREQ);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [2*NREQ-1:0] req_dbl, gnt_dbl;
  logic [NREQ-1:0]   req_rot, gnt_rot;
  logic              found;

  // Rotate so the pointer sits at bit 0, pick lowest set bit, rotate back.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found   = 1'b0;
    gnt_rot = '0;
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[NREQ-1:0];
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req_rot[off]) begin
        gnt_rot[off] = 1'b1;
        found        = 1'b1;
      end
    end
    gnt_dbl = {gnt_rot, gnt_rot} << ptr_q;
    gnt     = gnt_dbl[2*NREQ-1:NREQ];
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) ptr_d = PW'((i + 1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stappdi_eng_sched.sv
// Engine-side scheduler: RR-shares the controller's engine read/write ports, runs the
// init sweep (enabled by STAPPDI_INIT_SWEEP_EN) and returns tagged read data.
module stappdi_eng_sched
  import stappdi_pkg::*;
#(
  parameter int unsigned      NREQ     = 4,
  parameter int unsigned      ADDRBIT  = 5,
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      RDLAT    = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_start,
  input  logic [NREQ-1:0]         req_re,
  input  logic [NREQ*ADDRBIT-1:0] req_ra,
  output logic [NREQ-1:0]         req_rgnt,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*ADDRBIT-1:0] req_wa,
  input  logic [NREQ*WIDTH-1:0]   req_wrd,
  output logic [NREQ-1:0]         req_wgnt,
  output logic [NREQ-1:0]         rd_vld,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    eng_re,
  output logic [ADDRBIT-1:0]      eng_ra,
  input  logic [WIDTH-1:0]        eng_rdd,
  output logic                    eng_we,
  output logic [ADDRBIT-1:0]      eng_wa,
  output logic [WIDTH-1:0]        eng_wrd,
  output logic                    active,
  output logic                    init_busy
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("stappdi_eng_sched: NREQ out of range");
  end
  if (RDLAT < 1 || RDLAT > 4) begin : g_bad_rdlat
    $error("stappdi_eng_sched: RDLAT out of range");
  end

  localparam logic [ADDRBIT-1:0] ADDR_MAX = {ADDRBIT{1'b1}};

  state_e             state_q, state_d;
  logic [ADDRBIT-1:0] init_addr_q, init_addr_d;
  logic [NREQ-1:0]    rd_pipe_q [RDLAT];
  logic               run;

  assign run = (state_q == ST_RUN);

  stappdi_rr_arb #(.NREQ(NREQ)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (req_re & {NREQ{run}}),
    .gnt (req_rgnt)
  );

  stappdi_rr_arb #(.NREQ(NREQ)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (req_we & {NREQ{run}}),
    .gnt (req_wgnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef STAPPDI_INIT_SWEEP_EN
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!init_start && init_addr_q == ADDR_MAX) state_d = ST_RUN;
      ST_RUN:   if (init_start) state_d = ST_INIT;
`else
      ST_RESET: state_d = ST_RUN;
      ST_INIT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
`endif
      default:  state_d = ST_RESET;
    endcase
  end

  // Outside INIT the address parks at 0, so every sweep entry starts from the bottom.
  assign init_addr_d = (state_q == ST_INIT && !init_start) ? init_addr_q + 1'b1 : '0;

  always_comb begin
    active    = (state_q != ST_RESET);
`ifdef STAPPDI_INIT_SWEEP_EN
    init_busy = (state_q == ST_INIT);
`else
    init_busy = 1'b0;
`endif
    eng_re  = |req_rgnt;
    eng_we  = |req_wgnt;
    eng_ra  = '0;
    eng_wa  = '0;
    eng_wrd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_rgnt[i]) eng_ra = eng_ra | req_ra[i*ADDRBIT +: ADDRBIT];
      if (req_wgnt[i]) begin
        eng_wa  = eng_wa  | req_wa[i*ADDRBIT +: ADDRBIT];
        eng_wrd = eng_wrd | req_wrd[i*WIDTH +: WIDTH];
      end
    end
    if (state_q == ST_INIT) begin
      eng_we  = 1'b1;
      eng_wa  = init_addr_q;
      eng_wrd = INIT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the return pipe is a few flops of control, not storage, so it is cleared on reset to drop in-flight reads.
    if (rst) begin
      for (int k = 0; k < RDLAT; k++) rd_pipe_q[k] <= '0;
    end else begin
      rd_pipe_q[0] <= req_rgnt;
      for (int k = 1; k < RDLAT; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
    end
  end

  assign rd_vld  = rd_pipe_q[RDLAT-1];
  assign rd_data = (|rd_vld) ? eng_rdd : '0;

endmodule

// File: tb/tb_stappdi_eng_sched.sv
// Directed bench for stappdi_eng_sched; read returns are checked by a scoreboard monitor.
// Covers both builds of STAPPDI_INIT_SWEEP_EN.
module tb_stappdi_eng_sched;

  localparam int NREQ = 4, ADDRBIT = 5, WIDTH = 32, RDLAT = 3;

  logic                    clk = 1'b0;
  logic                    rst, init_start;
  logic [NREQ-1:0]         req_re, req_we, req_rgnt, req_wgnt, rd_vld;
  logic [NREQ*ADDRBIT-1:0] req_ra, req_wa;
  logic [NREQ*WIDTH-1:0]   req_wrd;
  logic [WIDTH-1:0]        rd_data, eng_rdd, eng_wrd;
  logic [ADDRBIT-1:0]      eng_ra, eng_wa;
  logic                    eng_re, eng_we, active, init_busy;

  stappdi_eng_sched #(
    .NREQ(NREQ), .ADDRBIT(ADDRBIT), .WIDTH(WIDTH), .RDLAT(RDLAT), .INIT_VAL('0)
  ) dut (
    .clk(clk), .rst(rst), .init_start(init_start),
    .req_re(req_re), .req_ra(req_ra), .req_rgnt(req_rgnt),
    .req_we(req_we), .req_wa(req_wa), .req_wrd(req_wrd), .req_wgnt(req_wgnt),
    .rd_vld(rd_vld), .rd_data(rd_data),
    .eng_re(eng_re), .eng_ra(eng_ra), .eng_rdd(eng_rdd),
    .eng_we(eng_we), .eng_wa(eng_wa), .eng_wrd(eng_wrd),
    .active(active), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: RAM preloaded on reset, read data RDLAT cycles after eng_re.
  logic [WIDTH-1:0] mem [32];
  logic [WIDTH-1:0] rdq [RDLAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) mem[a] <= 32'hD000_0000 | 32'(a);
    end else if (eng_we) begin
      mem[eng_wa] <= eng_wrd;
    end
    rdq[0] <= eng_re ? mem[eng_ra] : 32'hDEAD_BEEF;
    for (int k = 1; k < RDLAT; k++) rdq[k] <= rdq[k-1];
  end
  assign eng_rdd = rdq[RDLAT-1];

  function automatic logic [WIDTH-1:0] base(input int a);
`ifdef STAPPDI_INIT_SWEEP_EN
    return 32'h0;
`else
    return 32'hD000_0000 | 32'(a);
`endif
  endfunction

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]  vld;
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;
  exp_t sb[$];

  task automatic push_rd(input logic [NREQ-1:0] v, input int addr);
    exp_t e;
    e.vld  = v;
    e.data = base(addr);
    e.due  = cyc + RDLAT;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_vld != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_vld: got %b expected none (cycle %0d)", rd_vld, cyc);
      end else begin
        e = sb.pop_front();
        check("rd_vld", rd_vld, e.vld);
        check("rd_data", rd_data, e.data);
        check("rd_latency", cyc, e.due);
      end
    end else begin
      check("rd_data_idle", rd_data, 0);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL rd_vld_missing: got none expected %b due cycle %0d", e.vld, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int i, input int a);
    req_ra[i*ADDRBIT +: ADDRBIT] = ADDRBIT'(a);
  endtask

  task automatic set_w(input int i, input int a, input logic [WIDTH-1:0] d);
    req_wa[i*ADDRBIT +: ADDRBIT] = ADDRBIT'(a);
    req_wrd[i*WIDTH +: WIDTH]    = d;
  endtask

  task automatic check_sweep();
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      #1;
      check("sweep_we", eng_we, 1);
      check("sweep_wa", eng_wa, k);
      check("sweep_wrd", eng_wrd, 0);
      check("sweep_busy", init_busy, 1);
      check("sweep_no_rgnt", req_rgnt, 0);
    end
    tick();
    check("sweep_done_busy", init_busy, 0);
  endtask

  logic [NREQ-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int              rr_adr [5] = '{1, 2, 3, 4, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; init_start = 1'b0;
    req_re = '0; req_we = '0; req_ra = '0; req_wa = '0; req_wrd = '0;
    repeat (3) @(posedge clk);
    #1;
    req_re = 4'b1111; req_we = 4'b1111;
    #1;
    check("reset_rgnt", req_rgnt, 0);
    check("reset_wgnt", req_wgnt, 0);
    check("reset_active", active, 0);
    check("reset_busy", init_busy, 0);
    check("reset_eng_re", eng_re, 0);
    check("reset_eng_we", eng_we, 0);
    check("reset_rd_vld", rd_vld, 0);
    req_we = '0;
`ifndef STAPPDI_INIT_SWEEP_EN
    req_re = '0;
`endif
    rst = 1'b0;
    tick();
    check("post_reset_active", active, 1);
`ifdef STAPPDI_INIT_SWEEP_EN
    check_sweep();
    req_re = '0;
`else
    check("post_reset_busy", init_busy, 0);
    check("post_reset_we", eng_we, 0);
`endif

    // Round robin over all four readers.
    for (int i = 0; i < NREQ; i++) set_ra(i, i + 1);
    req_re = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      #1;
      check("rr_rgnt", req_rgnt, rr_seq[j]);
      check("rr_eng_re", eng_re, 1);
      check("rr_eng_ra", eng_ra, rr_adr[j]);
      push_rd(rr_seq[j], rr_adr[j]);
    end
    tick();
    req_re = '0;

    // Same-address read and write in one cycle.
    set_ra(1, 7); req_re = 4'b0010;
    set_w(2, 7, 32'hA5A5_0003); req_we = 4'b0100;
    #1;
    check("coll_rgnt", req_rgnt, 4'b0010);
    check("coll_wgnt", req_wgnt, 4'b0100);
    check("coll_eng_re", eng_re, 1);
    check("coll_eng_we", eng_we, 1);
    check("coll_eng_ra", eng_ra, 7);
    check("coll_eng_wa", eng_wa, 7);
    check("coll_eng_wrd", eng_wrd, 32'hA5A5_0003);
    push_rd(4'b0010, 7);

    // Write pointer at 3, only requester 1 asks.
    tick();
    req_re = '0;
    set_w(1, 9, 32'h0000_1234); req_we = 4'b0010;
    #1;
    check("wrap_wgnt", req_wgnt, 4'b0010);
    check("wrap_eng_wa", eng_wa, 9);
    check("wrap_eng_wrd", eng_wrd, 32'h0000_1234);
    tick();
    req_we = 4'b1111;
    #1;
    check("ptr2_wgnt", req_wgnt, 4'b0100);
    tick();
    req_we = '0;
    #1;
    check("idle_wgnt", req_wgnt, 0);
    check("idle_eng_we", eng_we, 0);
    tick();
    req_we = 4'b1010;
    #1;
    check("hold_wgnt", req_wgnt, 4'b1000);

    // init_start with a read in flight.
    tick();
    req_we = '0;
    set_ra(0, 2); req_re = 4'b0001; init_start = 1'b1;
    #1;
    check("istart_rgnt", req_rgnt, 4'b0001);
    push_rd(4'b0001, 2);
    tick();
    req_re = '0; init_start = 1'b0;
`ifdef STAPPDI_INIT_SWEEP_EN
    check_sweep();
`else
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      check("istart_no_we", eng_we, 0);
      check("istart_no_busy", init_busy, 0);
      check("istart_active", active, 1);
    end
    tick();
`endif

    // Back-to-back reads from requesters 2 and 3.
    set_ra(2, 12); set_ra(3, 13); req_re = 4'b1100;
    #1;
    check("b2b_rgnt0", req_rgnt, 4'b0100);
    check("b2b_ra0", eng_ra, 12);
    push_rd(4'b0100, 12);
    tick();
    #1;
    check("b2b_rgnt1", req_rgnt, 4'b1000);
    check("b2b_ra1", eng_ra, 13);
    push_rd(4'b1000, 13);
    tick();
    req_re = '0;
    repeat (RDLAT + 2) tick();
    check("sb_drained_pre_rst", sb.size(), 0);

    // Reset with a read in flight: its rd_vld must never appear.
    set_ra(0, 3); req_re = 4'b0001;
    #1;
    check("rst_rgnt", req_rgnt, 4'b0001);
    tick();
    req_re = '0; rst = 1'b1;
    tick();
    check("midrst_active", active, 0);
    check("midrst_rd_vld", rd_vld, 0);
    rst = 1'b0;
    repeat (RDLAT + 3) tick();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
